// File: rtl/prog_ctr_if.sv
// Control/data bundle between decode (master) and the program counter (slave).
interface prog_ctr_if #(
  parameter int W        = 8,
  parameter int NUM_OFFS = 4
);
  localparam int SEL_W = $clog2(NUM_OFFS);

  logic             Start;
  logic             Halt;
  logic [1:0]       Op;
  logic [W-1:0]     ValIn;
  logic             Cond;
  logic [SEL_W-1:0] OffSel;
  logic             TblWe;
  logic [SEL_W-1:0] TblIdx;
  logic [W-1:0]     TblData;
  logic [W-1:0]     CtrValue;
  logic [W-1:0]     PeekValue;
  logic             Running;
  logic             Done;
  logic             Wrapped;

  modport master (
    output Start, Halt, Op, ValIn, Cond, OffSel, TblWe, TblIdx, TblData,
    input  CtrValue, PeekValue, Running, Done, Wrapped
  );

  modport slave (
    input  Start, Halt, Op, ValIn, Cond, OffSel, TblWe, TblIdx, TblData,
    output CtrValue, PeekValue, Running, Done, Wrapped
  );
endinterface

// File: rtl/prog_ctr.sv
// W-bit program counter: increment / load / table-relative branch / hold,
// with a run-control FSM, sticky wrap flag and combinational branch-target peek.
//
// state    | meaning
// S_IDLE   | waiting for Start, counter holds, Op ignored
// S_RUN    | Op executes every cycle
// S_HALTED | counter frozen until Reset
module prog_ctr #(
  parameter int W        = 8,
  parameter int NUM_OFFS = 4,
  localparam int SEL_W   = $clog2(NUM_OFFS)
) (
  input logic       Clk,
  input logic       Reset,
  prog_ctr_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     ctr_q, ctr_d;
  logic             wrap_q, wrap_d;
  logic [W-1:0]     tbl [NUM_OFFS];
  logic [SEL_W-1:0] off_sel;
  logic [W-1:0]     off;
  logic [W:0]       inc;
  logic [W-1:0]     br_sum;
  logic             br_wrap;

  assign off_sel = bus.OffSel;
  assign off     = tbl[off_sel];
  assign inc     = {1'b0, ctr_q} + {{W{1'b0}}, 1'b1};
  assign br_sum  = ctr_q + off;
  // negative offsets wrap on borrow (result above old), others on carry (result below old)
  assign br_wrap = off[W-1] ? (br_sum > ctr_q) : (br_sum < ctr_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    wrap_d  = wrap_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Halt)       state_d = S_HALTED;
        else if (bus.Start) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.Halt) begin
          state_d = S_HALTED;
        end else begin
          case (bus.Op)
            2'b00: begin
              ctr_d  = inc[W-1:0];
              wrap_d = wrap_q | inc[W];
            end
            2'b01: ctr_d = bus.ValIn;
            2'b10: begin
              if (bus.Cond) begin
                ctr_d  = br_sum;
                wrap_d = wrap_q | br_wrap;
              end else begin
                ctr_d  = inc[W-1:0];
                wrap_d = wrap_q | inc[W];
              end
            end
            default: ctr_d = ctr_q;
          endcase
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // reads above see the pre-write entry, so same-cycle write/branch uses old data
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_OFFS; i++) tbl[i] <= '0;
    end else if (bus.TblWe) begin
      tbl[bus.TblIdx] <= bus.TblData;
    end
  end

  assign bus.CtrValue  = ctr_q;
  assign bus.PeekValue = ctr_q + off;
  assign bus.Running   = (state_q == S_RUN);
  assign bus.Done      = (state_q == S_HALTED);
  assign bus.Wrapped   = wrap_q;

endmodule
